i2c_write_scheduler: RTL and testbench

- Shares one I2C bus between two requesters and sequences a complete single-byte write on it: START, 7-bit address + W, ACK, 8 data bits, ACK, STOP.
- Generates the SCL/SDA waveforms that the bus-side sequence recognizers observe.
- Provides round-robin arbitration, a quarter-bit timing divider, ACK sampling and per-requester completion reporting.

---
 rtl/i2c_write_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_write_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_scheduler.sv
// Two-requester I2C single-byte write master: round-robin arbitration, quarter-bit
// timing, START / addr+W / ACK / data / ACK / STOP sequencing and per-requester completion.
module i2c_write_scheduler #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [6:0] addr0,
   input  logic [7:0] data0,
   input  logic [6:0] addr1,
   input  logic [7:0] data1,
   output logic [1:0] gnt,
   output logic [1:0] done,
   output logic       nack,
   output logic       busy,
   output logic       scl_o,
   output logic       sda_o,
   input  logic       sda_i
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_ACK1  = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_ACK2  = 3'd5;
   localparam logic [2:0] S_STOP  = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

   logic [2:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] qtr_q, qtr_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] addr_byte_q, addr_byte_d;
   logic [7:0] data_byte_q, data_byte_d;
   logic       owner_q, owner_d;
   logic       ptr_q, ptr_d;
   logic       nack_q, nack_d;
   logic [1:0] gnt_q, gnt_d;
   logic [1:0] done_q, done_d;
   logic       busy_q, busy_d;
   logic       scl_q, scl_d;
   logic       sda_q, sda_d;

   logic tick;
   logic active;
   logic win;

   assign tick   = (cnt_q == CNT_LAST);
   assign active = (state_q != S_IDLE) && (state_q != S_DONE);

   always_comb begin
      // NOTE: every variable gets a default first so no path through the case infers a latch.
      state_d     = state_q;
      cnt_d       = 8'd0;
      qtr_d       = qtr_q;
      bit_d       = bit_q;
      addr_byte_d = addr_byte_q;
      data_byte_d = data_byte_q;
      owner_d     = owner_q;
      ptr_d       = ptr_q;
      nack_d      = nack_q;
      gnt_d       = 2'b00;
      done_d      = 2'b00;
      busy_d      = busy_q;
      win         = 1'b0;

      if (active && !tick) cnt_d = cnt_q + 8'd1;

      // Operands are taken during the cycle gnt is visible to the requester.
      if (gnt_q != 2'b00) begin
         addr_byte_d = owner_q ? {addr1, 1'b0} : {addr0, 1'b0};
         data_byte_d = owner_q ? data1 : data0;
      end

      case (state_q)
         S_IDLE: begin
            if (req != 2'b00) begin
               win     = (req == 2'b11) ? ptr_q : req[1];
               owner_d = win;
               ptr_d   = ~win;
               gnt_d   = win ? 2'b10 : 2'b01;
               busy_d  = 1'b1;
               qtr_d   = 2'd0;
               bit_d   = 3'd0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd1) begin
                  qtr_d   = 2'd0;
                  bit_d   = 3'd0;
                  state_d = S_ADDR;
               end
            end
         end
         S_ADDR, S_DATA: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) begin
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = (state_q == S_ADDR) ? S_ACK1 : S_ACK2;
               end
            end
         end
         S_ACK1, S_ACK2: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd2 && sda_i) nack_d = 1'b1;
               if (qtr_q == 2'd3) begin
                  bit_d = 3'd0;
                  // An address NACK skips the data phase entirely.
                  if (state_q == S_ACK1 && !nack_q) state_d = S_DATA;
                  else                              state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd2) begin
                  qtr_d   = 2'd0;
                  done_d  = owner_q ? 2'b10 : 2'b01;
                  state_d = S_DONE;
               end
            end
         end
         default: begin
            nack_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Bus levels are decoded from next-state values and registered, keeping the pins glitch-free.
   always_comb begin
      scl_d = 1'b1;
      sda_d = 1'b1;
      case (state_d)
         S_START: sda_d = (qtr_d == 2'd0);
         S_ADDR: begin
            scl_d = qtr_d[1];
            sda_d = addr_byte_d[3'd7 - bit_d];
         end
         S_DATA: begin
            scl_d = qtr_d[1];
            sda_d = data_byte_d[3'd7 - bit_d];
         end
         S_ACK1, S_ACK2: scl_d = qtr_d[1];
         S_STOP: begin
            scl_d = (qtr_d != 2'd0);
            sda_d = (qtr_d == 2'd2);
         end
         default: begin
            scl_d = 1'b1;
            sda_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         qtr_q       <= 2'd0;
         bit_q       <= 3'd0;
         addr_byte_q <= 8'd0;
         data_byte_q <= 8'd0;
         owner_q     <= 1'b0;
         ptr_q       <= 1'b0;
         nack_q      <= 1'b0;
         gnt_q       <= 2'b00;
         done_q      <= 2'b00;
         busy_q      <= 1'b0;
         scl_q       <= 1'b1;
         sda_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         qtr_q       <= qtr_d;
         bit_q       <= bit_d;
         addr_byte_q <= addr_byte_d;
         data_byte_q <= data_byte_d;
         owner_q     <= owner_d;
         ptr_q       <= ptr_d;
         nack_q      <= nack_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         scl_q       <= scl_d;
         sda_q       <= sda_d;
      end
   end

   assign gnt   = gnt_q;
   assign done  = done_q;
   assign nack  = nack_q;
   assign busy  = busy_q;
   assign scl_o = scl_q;
   assign sda_o = sda_q;

endmodule

// File: tb/tb_i2c_write_scheduler.sv
// Directed bench for i2c_write_scheduler: one instance at CLK_DIV=2 (a_*) and one at
// CLK_DIV=1 (b_*), with bus-legality monitoring on both.
module tb_i2c_write_scheduler;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [1:0] a_req, a_gnt, a_done;
   logic [6:0] a_addr0, a_addr1;
   logic [7:0] a_data0, a_data1;
   logic       a_nack, a_busy, a_scl, a_sda, a_sda_i;

   logic [1:0] b_req, b_gnt, b_done;
   logic [6:0] b_addr0, b_addr1;
   logic [7:0] b_data0, b_data1;
   logic       b_nack, b_busy, b_scl, b_sda, b_sda_i;

   i2c_write_scheduler #(.CLK_DIV(2)) dut_a (
      .clk(clk), .reset(reset), .req(a_req),
      .addr0(a_addr0), .data0(a_data0), .addr1(a_addr1), .data1(a_data1),
      .gnt(a_gnt), .done(a_done), .nack(a_nack), .busy(a_busy),
      .scl_o(a_scl), .sda_o(a_sda), .sda_i(a_sda_i)
   );

   i2c_write_scheduler #(.CLK_DIV(1)) dut_b (
      .clk(clk), .reset(reset), .req(b_req),
      .addr0(b_addr0), .data0(b_data0), .addr1(b_addr1), .data1(b_data1),
      .gnt(b_gnt), .done(b_done), .nack(b_nack), .busy(b_busy),
      .scl_o(b_scl), .sda_o(b_sda), .sda_i(b_sda_i)
   );

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // SDA may change only while SCL is low, apart from START (fall) and STOP (rise) with SCL high.
   logic mon_en = 1'b0;
   int   n_viol = 0, n_start = 0, n_stop = 0;
   logic pa_scl = 1'b1, pa_sda = 1'b1, pb_scl = 1'b1, pb_sda = 1'b1;

   task automatic mon_step(input logic scl, input logic sda, input logic pscl, input logic psda);
      if (sda !== psda && scl !== 1'b0) begin
         if (pscl === 1'b1 && psda === 1'b1 && sda === 1'b0)      n_start++;
         else if (pscl === 1'b1 && psda === 1'b0 && sda === 1'b1) n_stop++;
         else                                                     n_viol++;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_step(a_scl, a_sda, pa_scl, pa_sda);
         mon_step(b_scl, b_sda, pb_scl, pb_sda);
      end
      pa_scl = a_scl; pa_sda = a_sda;
      pb_scl = b_scl; pb_sda = b_sda;
   end

   task automatic wait_gnt(input bit sel, output int waited, output logic [1:0] g);
      waited = 0;
      g = sel ? b_gnt : a_gnt;
      for (int i = 0; i < 20; i++) begin
         g = sel ? b_gnt : a_gnt;
         if (g != 2'b00) break;
         tick();
         waited++;
      end
   endtask

   // Called in the gnt cycle; returns in the done cycle (or after the cycle bound).
   task automatic run_txn(input bit sel, input int sda_sw, input bit scramble,
                          output logic [1:0] g_next, output logic [1:0] d, output logic nk,
                          output int lat, output logic [31:0] bits, output int nbits);
      logic prev_scl, cur_scl, cur_sda;
      lat = 0; bits = 0; nbits = 0; g_next = 2'b00;
      prev_scl = sel ? b_scl : a_scl;
      if (sel) b_sda_i = (sda_sw <= 0); else a_sda_i = (sda_sw <= 0);
      for (int i = 0; i < 400; i++) begin
         tick();
         lat++;
         if (lat == 1) begin
            g_next = sel ? b_gnt : a_gnt;
            if (scramble) begin
               a_addr0 = 7'h7F;
               a_data0 = 8'h00;
            end
         end
         if (sel) b_sda_i = (lat >= sda_sw); else a_sda_i = (lat >= sda_sw);
         cur_scl = sel ? b_scl : a_scl;
         cur_sda = sel ? b_sda : a_sda;
         if (!prev_scl && cur_scl) begin
            bits = {bits[30:0], cur_sda};
            nbits++;
         end
         prev_scl = cur_scl;
         if ((sel ? b_done : a_done) != 2'b00) break;
      end
      d  = sel ? b_done : a_done;
      nk = sel ? b_nack : a_nack;
   endtask

   initial begin
      int          waited, lat, nbits;
      logic [1:0]  g, g_next, d;
      logic        nk;
      logic [31:0] bits;

      reset = 1'b1;
      a_req = 2'b00; a_addr0 = 7'h00; a_data0 = 8'h00; a_addr1 = 7'h00; a_data1 = 8'h00; a_sda_i = 1'b0;
      b_req = 2'b00; b_addr0 = 7'h00; b_data0 = 8'h00; b_addr1 = 7'h00; b_data1 = 8'h00; b_sda_i = 1'b0;
      tick();
      tick();

      chk("reset_gnt",  a_gnt,  2'b00);
      chk("reset_done", a_done, 2'b00);
      chk("reset_nack", a_nack, 1'b0);
      chk("reset_busy", a_busy, 1'b0);
      chk("reset_scl",  a_scl,  1'b1);
      chk("reset_sda",  a_sda,  1'b1);
      chk("reset_b_bus", {b_scl, b_sda, b_busy}, 3'b110);

      reset  = 1'b0;
      mon_en = 1'b1;
      tick();

      // Single ACKed write, CLK_DIV=2; operands scrambled after capture.
      a_addr0 = 7'h50; a_data0 = 8'hA5; a_sda_i = 1'b0; a_req = 2'b01;
      wait_gnt(0, waited, g);
      chk("t1_gnt", g, 2'b01);
      chk("t1_busy_at_gnt", a_busy, 1'b1);
      run_txn(0, 1000, 1, g_next, d, nk, lat, bits, nbits);
      a_req = 2'b00;
      chk("t1_gnt_one_cycle", g_next, 2'b00);
      chk("t1_done", d, 2'b01);
      chk("t1_nack", nk, 1'b0);
      chk("t1_latency", lat, 154);
      chk("t1_scl_rises", nbits, 19);
      chk("t1_sda_bits", bits, 32'({8'hA0, 1'b1, 8'hA5, 2'b10}));
      chk("t1_busy_at_done", a_busy, 1'b1);
      tick();
      chk("t1_done_pulse", a_done, 2'b00);
      chk("t1_busy_after", a_busy, 1'b0);

      // Address NACK from requester 1, CLK_DIV=2.
      a_addr1 = 7'h3C; a_data1 = 8'hFF; a_sda_i = 1'b1; a_req = 2'b10;
      wait_gnt(0, waited, g);
      chk("t2_gnt", g, 2'b10);
      run_txn(0, 0, 0, g_next, d, nk, lat, bits, nbits);
      a_req = 2'b00;
      chk("t2_done", d, 2'b10);
      chk("t2_nack", nk, 1'b1);
      chk("t2_latency", lat, 82);
      chk("t2_scl_rises", nbits, 10);
      chk("t2_sda_bits", bits, 32'({8'h78, 2'b10}));
      tick();
      chk("t2_nack_cleared", a_nack, 1'b0);
      a_sda_i = 1'b0;

      // Data NACK, CLK_DIV=1: ACK1 low, ACK2 high.
      b_addr0 = 7'h2A; b_data0 = 8'h96; b_req = 2'b01;
      wait_gnt(1, waited, g);
      chk("t3_gnt", g, 2'b01);
      run_txn(1, 50, 0, g_next, d, nk, lat, bits, nbits);
      b_req = 2'b00;
      chk("t3_done", d, 2'b01);
      chk("t3_nack", nk, 1'b1);
      chk("t3_latency", lat, 77);
      chk("t3_sda_bits", bits, 32'({8'h54, 1'b1, 8'h96, 2'b10}));
      tick();

      // Round-robin under continuous requests from reset.
      reset = 1'b1;
      a_addr0 = 7'h11; a_data0 = 8'h5A; a_addr1 = 7'h33; a_data1 = 8'hC3; a_req = 2'b11;
      tick();
      tick();
      reset = 1'b0;
      wait_gnt(0, waited, g);
      chk("t4_gnt_1st", g, 2'b01);
      run_txn(0, 1000, 0, g_next, d, nk, lat, bits, nbits);
      chk("t4_done_1st", d, 2'b01);
      chk("t4_bits_1st", bits, 32'({8'h22, 1'b1, 8'h5A, 2'b10}));
      wait_gnt(0, waited, g);
      chk("t4_gap_2nd", waited, 2);
      chk("t4_gnt_2nd", g, 2'b10);
      chk("t4_busy_2nd", a_busy, 1'b1);
      run_txn(0, 1000, 0, g_next, d, nk, lat, bits, nbits);
      chk("t4_done_2nd", d, 2'b10);
      chk("t4_bits_2nd", bits, 32'({8'h66, 1'b1, 8'hC3, 2'b10}));
      wait_gnt(0, waited, g);
      chk("t4_gap_3rd", waited, 2);
      chk("t4_gnt_3rd", g, 2'b01);
      run_txn(0, 1000, 0, g_next, d, nk, lat, bits, nbits);
      a_req = 2'b00;
      chk("t4_done_3rd", d, 2'b01);
      chk("t4_bits_3rd", bits, 32'({8'h22, 1'b1, 8'h5A, 2'b10}));
      tick();
      tick();

      chk("bus_violations", n_viol, 0);
      chk("bus_starts", n_start, 6);
      chk("bus_stops", n_stop, 6);
      mon_en = 1'b0;

      // Reset during the 4th address bit.
      a_addr0 = 7'h50; a_data0 = 8'hA5; a_req = 2'b01;
      wait_gnt(0, waited, g);
      chk("t5_gnt", g, 2'b01);
      for (int i = 0; i < 30; i++) tick();
      chk("t5_scl_low_in_bit3", a_scl, 1'b0);
      reset = 1'b1;
      a_req = 2'b11;
      tick();
      chk("t5_bus_released", {a_scl, a_sda}, 2'b11);
      chk("t5_busy", a_busy, 1'b0);
      chk("t5_no_done", a_done, 2'b00);
      chk("t5_no_gnt", a_gnt, 2'b00);
      tick();
      reset = 1'b0;
      wait_gnt(0, waited, g);
      chk("t5_gnt_after_reset", g, 2'b01);
      a_req = 2'b00;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
